// File: rtl/rds_bit_serializer.sv
// rds_bit_serializer
//   Serializes the pre-encoded RDS message table (message::rds_msg_map) into
//   the RDS bit stream, MSB first, one bit per bit_tick, with continuous
//   differential encoding. The message loops endlessly.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   en           enable; low pauses and holds all state (ticks dropped)
//   restart      sync pulse: rewind to byte 0 bit 7, clear diff memory
//   bit_tick     one-cycle strobe at the RDS bit rate
//   rds_data     raw message bit currently presented
//   rds_diff     differentially encoded bit (previous rds_diff ^ rds_data)
//   bit_valid    one-cycle pulse when rds_data/rds_diff are new
//   group_start  with bit_valid, marks bit 7 of a group's first byte
//   grp_idx      group index of the presented bit

package message;
  localparam int unsigned RDS_MSG_BYTES = 52;

  // 4 groups x 13 bytes (4 blocks x 26 bits, checkwords included)
  localparam logic [7:0] rds_msg_map [RDS_MSG_BYTES] = '{
    8'hCA, 8'hFE, 8'hA0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'h55,
    8'h3C, 8'h81, 8'h7E, 8'h24, 8'hC3, 8'h99, 8'h66, 8'hA5, 8'h5A, 8'h18, 8'hE7, 8'h42, 8'hBD,
    8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76,
    8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h51
  };
endpackage

module rds_bit_serializer #(
  parameter int NUM_GROUPS      = 4,
  parameter int BYTES_PER_GROUP = 13
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          restart,
  input  logic                          bit_tick,
  output logic                          rds_data,
  output logic                          rds_diff,
  output logic                          bit_valid,
  output logic                          group_start,
  output logic [$clog2(NUM_GROUPS)-1:0] grp_idx
);

  localparam int TOTAL_BYTES = NUM_GROUPS * BYTES_PER_GROUP;
  localparam int BW          = $clog2(TOTAL_BYTES);
  localparam int GBW         = $clog2(BYTES_PER_GROUP);
  localparam int GW          = $clog2(NUM_GROUPS);

  localparam logic [BW-1:0]  LAST_BYTE   = BW'(TOTAL_BYTES - 1);
  localparam logic [GBW-1:0] LAST_IN_GRP = GBW'(BYTES_PER_GROUP - 1);

  logic [BW-1:0]  r_byte_ptr;
  logic [2:0]     r_bit_ptr;
  logic [GBW-1:0] r_byte_in_grp;   // byte position within the current group
  logic [GW-1:0]  r_grp_cnt;       // group of the byte at r_byte_ptr
  logic           r_data;
  logic           r_diff;
  logic           r_valid;
  logic           r_group_start;
  logic [GW-1:0]  r_grp_idx;

  logic w_src_bit;
  logic w_emit;
  logic w_grp_first_bit;

  assign w_src_bit       = message::rds_msg_map[r_byte_ptr][r_bit_ptr];
  assign w_emit          = en & bit_tick & ~restart;
  // Group boundaries come from a within-group byte counter so no divider or
  // modulo is needed on the byte pointer.
  assign w_grp_first_bit = (r_byte_in_grp == '0) && (r_bit_ptr == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_ptr    <= '0;
      r_bit_ptr     <= 3'd7;
      r_byte_in_grp <= '0;
      r_grp_cnt     <= '0;
      r_data        <= 1'b0;
      r_diff        <= 1'b0;
      r_valid       <= 1'b0;
      r_group_start <= 1'b0;
      r_grp_idx     <= '0;
    end else begin
      r_valid       <= 1'b0;
      r_group_start <= 1'b0;
      if (restart) begin
        r_byte_ptr    <= '0;
        r_bit_ptr     <= 3'd7;
        r_byte_in_grp <= '0;
        r_grp_cnt     <= '0;
        r_data        <= 1'b0;
        r_diff        <= 1'b0;
      end else if (w_emit) begin
        r_data        <= w_src_bit;
        r_diff        <= r_diff ^ w_src_bit;
        r_valid       <= 1'b1;
        r_group_start <= w_grp_first_bit;
        r_grp_idx     <= r_grp_cnt;
        if (r_bit_ptr == 3'd0) begin
          r_bit_ptr <= 3'd7;
          if (r_byte_ptr == LAST_BYTE) begin
            r_byte_ptr    <= '0;
            r_byte_in_grp <= '0;
            r_grp_cnt     <= '0;
          end else begin
            r_byte_ptr <= r_byte_ptr + 1'b1;
            if (r_byte_in_grp == LAST_IN_GRP) begin
              r_byte_in_grp <= '0;
              r_grp_cnt     <= r_grp_cnt + 1'b1;
            end else begin
              r_byte_in_grp <= r_byte_in_grp + 1'b1;
            end
          end
        end else begin
          r_bit_ptr <= r_bit_ptr - 1'b1;
        end
      end
    end
  end

  assign rds_data    = r_data;
  assign rds_diff    = r_diff;
  assign bit_valid   = r_valid;
  assign group_start = r_group_start;
  assign grp_idx     = r_grp_idx;

endmodule

// File: doc/rds_bit_serializer.md
# rds_bit_serializer

Serializes the RDS message held in the `message` package constant `rds_msg_map` into the 1187.5 bit/s RDS data stream. It walks the 4 pre-encoded groups (13 bytes = 104 bits each: 4 blocks × 26 bits, checkwords included) MSB-first, applies RDS differential encoding, and presents one bit per `bit_tick` to the downstream biphase/BPSK modulator on the 57 kHz subcarrier. The message loops endlessly.

## Interface
Parameters:
- `NUM_GROUPS`, 4: groups in the message table.
- `BYTES_PER_GROUP`, 13: bytes per group (104 bits).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  serializer enable; low = pause and hold all state.
- `restart`  in  1  synchronous one-cycle pulse: rewind to byte 0, bit 7.
- `bit_tick`  in  1  one-cycle strobe at the RDS bit rate, from the upstream divider.
- `rds_data`  out  1  raw message bit currently presented.
- `rds_diff`  out  1  differentially encoded bit: `rds_diff = rds_diff_prev ^ rds_data`.
- `bit_valid`  out  1  one-cycle pulse; new `rds_data`/`rds_diff` this cycle.
- `group_start`  out  1  high with `bit_valid` when the presented bit is bit 7 of a group's first byte.
- `grp_idx`  out  $clog2(NUM_GROUPS)  group of the presented bit.

## Operation
- State: byte pointer `byte_ptr` 0..NUM_GROUPS*BYTES_PER_GROUP-1 (0..51), bit pointer `bit_ptr` 7..0, differential memory.
- Bit source: `rds_msg_map[byte_ptr][bit_ptr]`, MSB first.
- Emission, when `en && bit_tick && !restart`: register `rds_data` = source bit; `rds_diff` ← `rds_diff ^ source bit`; pulse `bit_valid`; set `group_start` if `byte_ptr % BYTES_PER_GROUP == 0 && bit_ptr == 7`; set `grp_idx` = `byte_ptr / BYTES_PER_GROUP`. Then advance: `bit_ptr` decrements. At 0 it reloads to 7 and `byte_ptr` increments. At 51 `byte_ptr` wraps to 0.
- `grp_idx` uses a group counter incremented at group boundaries, not a divider.
- `en` low: pointers, `rds_data`, `rds_diff` and `grp_idx` hold; `bit_valid` and `group_start` are 0; ticks are ignored, not queued. Re-asserting `en` resumes at the held position.
- `restart`: `byte_ptr`←0, `bit_ptr`←7, group counter ←0, `rds_diff` memory ←0, `rds_data`←0. No bit is emitted that cycle, even with `bit_tick`, and regardless of `en`. `restart` has priority over `bit_tick`.
- Differential encoding is continuous across the group and message wrap. Only reset and `restart` clear it.

## Timing
- Reset values: `rds_data`=0, `rds_diff`=0, `bit_valid`=0, `group_start`=0, `grp_idx`=0, `byte_ptr`=0, `bit_ptr`=7.
- Latency: all outputs are registered and update on the clock edge ending the `bit_tick` cycle. `bit_valid` is high the cycle after the tick, for 1 cycle.
- `rds_data`/`rds_diff` are stable between emissions.
- Back-to-back `bit_tick` every cycle is supported at one bit per cycle with no bubbles.
- `rst` asserted mid-byte clears immediately (async). Deassertion is synchronized externally. The first tick after reset emits byte 0 bit 7.
- Message period: 416 emissions. `group_start` occurs on emissions 1, 105, 209, 313, 417, …

## Test plan
- Reset, `en`=1, 8 ticks spaced 10 cycles:
  - `rds_data` = 1,1,0,0,1,0,1,0 (0xCA).
  - `rds_diff` = 1,0,0,0,1,1,0,0.
  - `group_start` is high only on the first bit; `grp_idx`=0.
- 416 consecutive ticks:
  - `group_start` on emissions 1, 105, 209, 313, with `grp_idx` 0,1,2,3.
  - Emissions 409..416 are 0,1,0,1,0,0,0,1 (0x51).
  - Emission 417 is 1 (0xCA MSB) with `group_start`=1, `grp_idx`=0.
  - `rds_diff` continues without clearing.
- Pause: drop `en` after emission 5, apply 20 ticks, re-enable.
  - No `bit_valid` while paused; outputs hold.
  - The next emission is byte 0 bit 2 (=0).
- `restart` together with `bit_tick` after emission 12:
  - No `bit_valid` that cycle; `rds_data`=0 and `rds_diff`=0 after that edge.
  - The next tick emits 1 (0xCA MSB) with `group_start`=1.
- Tick every cycle for 20 cycles: 20 consecutive `bit_valid` pulses, sequence equal to 0xCA, 0xFE, 0xA0 MSB-first (first 20 bits).
- Assert `rst` asynchronously mid-byte 3 (between clock edges):
  - All outputs go to their reset values before the next edge.
  - After release, the first tick emits byte 0 bit 7.
